// File: rtl/mac_bus_pkg.sv
// Shared definitions for the time-division RAM bus: owner codes, phase count
// and the phase-advance helper used by the slot scheduler.
package mac_bus_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int BUS_PHASES = 4;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_SND  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return 2'((int'(p) + 1) % BUS_PHASES);
    endfunction

endpackage

// File: rtl/slot_arbiter.sv
// Combinational owner pick for the slot being entered: fixed priority in
// slot 0, CPU-only in the reserved CPU slot, idle elsewhere.
module slot_arbiter
    import mac_bus_pkg::*;
#(
    parameter int CPU_SLOT = 2
)(
    input  logic [1:0] i_phase,
    input  logic       i_vid_load,
    input  logic       i_snd_req,
    input  logic       i_cpu_ok,
    output logic [1:0] o_owner
);

    always_comb begin
        o_owner = OWN_IDLE;
        if (i_phase == 2'd0) begin
            if (i_vid_load) begin
                o_owner = OWN_VID;
            end else if (i_snd_req) begin
                o_owner = OWN_SND;
            end else if (i_cpu_ok) begin
                o_owner = OWN_CPU;
            end
        end else if (i_phase == 2'(CPU_SLOT)) begin
            if (i_cpu_ok) begin
                o_owner = OWN_CPU;
            end
        end
    end

endmodule

// File: rtl/mem_slot_scheduler.sv
// Time-division scheduler for the shared RAM bus: generates busCycle and
// assigns each slot to video, DMA or CPU with registered RAM strobes.
module mem_slot_scheduler
    import mac_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CPU_SLOT = 2
)(
    input  logic              clk,
    input  logic              _reset,
    input  logic              clk_en,
    output logic [1:0]        busCycle,
    input  logic              vid_load,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              snd_req,
    input  logic [ADDR_W-1:0] snd_addr,
    output logic              snd_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [1:0]        mem_owner
);

    logic [1:0]        r_bus_cycle;
    logic [1:0]        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_oe;
    logic              r_we;
    logic              r_snd_ack;
    logic              r_cpu_ack;
    logic              r_cpu_out;

    logic [1:0]        w_next_phase;
    logic [1:0]        w_grant;
    logic              w_cpu_ok;

    assign w_next_phase = next_phase(r_bus_cycle);
    assign w_cpu_ok     = cpu_req & ~r_cpu_out;

    slot_arbiter #(
        .CPU_SLOT (CPU_SLOT)
    ) u_arb (
        .i_phase    (w_next_phase),
        .i_vid_load (vid_load),
        .i_snd_req  (snd_req),
        .i_cpu_ok   (w_cpu_ok),
        .o_owner    (w_grant)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_bus_cycle <= 2'd0;
            r_owner     <= OWN_IDLE;
            r_addr      <= '0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_snd_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_out   <= 1'b0;
        end else begin
            // Acks are one-clk pulses on the edge that leaves the owning slot.
            r_snd_ack <= clk_en && (r_owner == OWN_SND);
            r_cpu_ack <= clk_en && (r_owner == OWN_CPU);
            if (clk_en) begin
                r_bus_cycle <= w_next_phase;
                r_owner     <= w_grant;
                case (w_grant)
                    OWN_VID: begin
                        r_addr <= vid_addr;
                        r_oe   <= 1'b1;
                        r_we   <= 1'b0;
                    end
                    OWN_SND: begin
                        r_addr <= snd_addr;
                        r_oe   <= 1'b1;
                        r_we   <= 1'b0;
                    end
                    OWN_CPU: begin
                        r_addr <= cpu_addr;
                        r_oe   <= ~cpu_we;
                        r_we   <= cpu_we;
                    end
                    default: begin
                        r_oe <= 1'b0;
                        r_we <= 1'b0;
                    end
                endcase
                // A held request must drop once before the CPU is served again.
                if (w_grant == OWN_CPU) begin
                    r_cpu_out <= 1'b1;
                end else if (!cpu_req) begin
                    r_cpu_out <= 1'b0;
                end
            end
        end
    end

    assign busCycle  = r_bus_cycle;
    assign mem_owner = r_owner;
    assign mem_addr  = r_addr;
    assign mem_oe    = r_oe;
    assign mem_we    = r_we;
    assign snd_ack   = r_snd_ack;
    assign cpu_ack   = r_cpu_ack;

endmodule
